// File: rtl/pcie_tl_vc_scheduler_pkg.sv
// Shared types and constants for the PCIe TL VC scheduler.
// Holds TLP width, FSM state encoding and fmt decoding helper.
package PCIe_PKG;

  localparam int PCIe_TL_TLP_PACKET_SIZE = 224;
  localparam int CRD_W = 8;

  typedef enum logic {
    SERVE_VC0 = 1'b0,
    SERVE_VC1 = 1'b1
  } sched_state_t;

  function automatic logic tlp_has_data(input logic [2:0] fmt);
    return fmt[1];
  endfunction

endpackage

// File: rtl/pcie_tl_vc_scheduler_if.sv
// FIFO, data-link and credit-return signals of the VC scheduler.
// master is the scheduler side, slave is the surrounding logic.
interface pcie_tl_vc_scheduler_if;
  import PCIe_PKG::*;

  logic                               vc0_empty_i;
  logic                               vc1_empty_i;
  logic [PCIe_TL_TLP_PACKET_SIZE-1:0] vc0_rdata_i;
  logic [PCIe_TL_TLP_PACKET_SIZE-1:0] vc1_rdata_i;
  logic                               vc0_rden_o;
  logic                               vc1_rden_o;
  logic                               tlp_valid_o;
  logic [PCIe_TL_TLP_PACKET_SIZE-1:0] tlp_o;
  logic                               tlp_ready_i;
  logic                               crd_ret_valid_i;
  logic                               crd_ret_vc_i;
  logic [3:0]                         crd_ret_hdr_i;
  logic [3:0]                         crd_ret_data_i;
  logic                               vc0_fc_valid_o;
  logic                               vc1_fc_valid_o;
  logic                               grant_vc_o;

  modport master (
    input  vc0_empty_i, vc1_empty_i,
    input  vc0_rdata_i, vc1_rdata_i,
    input  tlp_ready_i,
    input  crd_ret_valid_i, crd_ret_vc_i,
    input  crd_ret_hdr_i, crd_ret_data_i,
    output vc0_rden_o, vc1_rden_o,
    output tlp_valid_o, tlp_o, grant_vc_o,
    output vc0_fc_valid_o, vc1_fc_valid_o
  );

  modport slave (
    output vc0_empty_i, vc1_empty_i,
    output vc0_rdata_i, vc1_rdata_i,
    output tlp_ready_i,
    output crd_ret_valid_i, crd_ret_vc_i,
    output crd_ret_hdr_i, crd_ret_data_i,
    input  vc0_rden_o, vc1_rden_o,
    input  tlp_valid_o, tlp_o, grant_vc_o,
    input  vc0_fc_valid_o, vc1_fc_valid_o
  );

endinterface

// File: rtl/pcie_tl_vc_scheduler_credit_cnt.sv
// Per-VC header/data credit counters.
// Consume on grant, add on return, saturate at the initial value.
module pcie_tl_vc_credit_cnt
  import PCIe_PKG::*;
#(
  parameter int INIT_HDR  = 16,
  parameter int INIT_DATA = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take_hdr,
  input  logic             take_data,
  input  logic             ret_valid,
  input  logic [3:0]       ret_hdr,
  input  logic [3:0]       ret_data,
  output logic [CRD_W-1:0] hdr_crd,
  output logic [CRD_W-1:0] data_crd
);

  localparam logic [CRD_W:0] LIM_H = (CRD_W+1)'(INIT_HDR);
  localparam logic [CRD_W:0] LIM_D = (CRD_W+1)'(INIT_DATA);

  function automatic logic [CRD_W-1:0] next_crd(
    input logic [CRD_W-1:0] cur,
    input logic             take,
    input logic [3:0]       ret,
    input logic [CRD_W:0]   lim
  );
    logic [CRD_W:0] s;
    s = {1'b0, cur} - (CRD_W+1)'(take) + (CRD_W+1)'(ret);
    return (s > lim) ? lim[CRD_W-1:0] : s[CRD_W-1:0];
  endfunction

  logic [3:0] rh;
  logic [3:0] rd;

  assign rh = ret_valid ? ret_hdr  : 4'd0;
  assign rd = ret_valid ? ret_data : 4'd0;

  // credit registers: consume and return folded into one saturating update
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_crd  <= LIM_H[CRD_W-1:0];
      data_crd <= LIM_D[CRD_W-1:0];
    end else begin
      hdr_crd  <= next_crd(hdr_crd, take_hdr, rh, LIM_H);
      data_crd <= next_crd(data_crd, take_data, rd, LIM_D);
    end
  end

endmodule

// File: rtl/pcie_tl_vc_scheduler.sv
// Weighted round-robin TLP scheduler across two virtual channels.
// Credit-gated FIFO heads feed a single registered output stage.
module pcie_tl_vc_scheduler
  import PCIe_PKG::*;
#(
  parameter int WEIGHT_VC0    = 3,
  parameter int WEIGHT_VC1    = 1,
  parameter int INIT_HDR_CRD  = 16,
  parameter int INIT_DATA_CRD = 16
) (
  input logic                    clk,
  input logic                    rst,
  pcie_tl_vc_scheduler_if.master bus
);

  localparam logic [3:0] W0 = 4'(WEIGHT_VC0);
  localparam logic [3:0] W1 = 4'(WEIGHT_VC1);

  sched_state_t     state;
  sched_state_t     state_n;
  logic [3:0]       cnt;
  logic [3:0]       cnt_n;
  logic             gnt;
  logic             gnt_vc;
  logic             load;
  logic             has0;
  logic             has1;
  logic             elig0;
  logic             elig1;
  logic [CRD_W-1:0] hdr0;
  logic [CRD_W-1:0] hdr1;
  logic [CRD_W-1:0] dat0;
  logic [CRD_W-1:0] dat1;

  assign has0  = tlp_has_data(bus.vc0_rdata_i[223:221]);
  assign has1  = tlp_has_data(bus.vc1_rdata_i[223:221]);
  assign elig0 = !bus.vc0_empty_i && (hdr0 != '0)
               && (!has0 || (dat0 != '0));
  assign elig1 = !bus.vc1_empty_i && (hdr1 != '0)
               && (!has1 || (dat1 != '0));
  assign load  = !bus.tlp_valid_o || bus.tlp_ready_i;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SERVE_VC0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state: serve current VC up to its weight, else steal a turn
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt     = 1'b0;
    gnt_vc  = 1'b0;
    if (load && !rst) begin
      unique case (state)
        SERVE_VC0: begin
          if (elig0) begin
            gnt   = 1'b1;
            cnt_n = cnt + 4'd1;
            if (cnt_n >= W0) begin
              state_n = SERVE_VC1;
              cnt_n   = '0;
            end
          end else if (elig1) begin
            gnt     = 1'b1;
            gnt_vc  = 1'b1;
            state_n = SERVE_VC1;
            cnt_n   = 4'd1;
          end
        end
        SERVE_VC1: begin
          if (elig1) begin
            gnt    = 1'b1;
            gnt_vc = 1'b1;
            cnt_n  = cnt + 4'd1;
            if (cnt_n >= W1) begin
              state_n = SERVE_VC0;
              cnt_n   = '0;
            end
          end else if (elig0) begin
            gnt     = 1'b1;
            state_n = SERVE_VC0;
            cnt_n   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs: pop the granted FIFO in the same cycle
  always_comb begin
    bus.vc0_rden_o = gnt && !gnt_vc;
    bus.vc1_rden_o = gnt && gnt_vc;
  end

  // output stage: load on free slot, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tlp_valid_o <= 1'b0;
      bus.tlp_o       <= '0;
      bus.grant_vc_o  <= 1'b0;
    end else if (load) begin
      bus.tlp_valid_o <= gnt;
      if (gnt) begin
        bus.tlp_o      <= gnt_vc ? bus.vc1_rdata_i : bus.vc0_rdata_i;
        bus.grant_vc_o <= gnt_vc;
      end
    end
  end

  assign bus.vc0_fc_valid_o = (hdr0 != '0);
  assign bus.vc1_fc_valid_o = (hdr1 != '0);

  pcie_tl_vc_credit_cnt #(
    .INIT_HDR  (INIT_HDR_CRD),
    .INIT_DATA (INIT_DATA_CRD)
  ) u_crd0 (
    .clk       (clk),
    .rst       (rst),
    .take_hdr  (bus.vc0_rden_o),
    .take_data (bus.vc0_rden_o && has0),
    .ret_valid (bus.crd_ret_valid_i && !bus.crd_ret_vc_i),
    .ret_hdr   (bus.crd_ret_hdr_i),
    .ret_data  (bus.crd_ret_data_i),
    .hdr_crd   (hdr0),
    .data_crd  (dat0)
  );

  pcie_tl_vc_credit_cnt #(
    .INIT_HDR  (INIT_HDR_CRD),
    .INIT_DATA (INIT_DATA_CRD)
  ) u_crd1 (
    .clk       (clk),
    .rst       (rst),
    .take_hdr  (bus.vc1_rden_o),
    .take_data (bus.vc1_rden_o && has1),
    .ret_valid (bus.crd_ret_valid_i && bus.crd_ret_vc_i),
    .ret_hdr   (bus.crd_ret_hdr_i),
    .ret_data  (bus.crd_ret_data_i),
    .hdr_crd   (hdr1),
    .data_crd  (dat1)
  );

endmodule

// File: tb/tb_pcie_tl_vc_scheduler.sv
// Bench for pcie_tl_vc_scheduler: table vectors, directed sequences
// and random traffic against a queue-based reference model.
module tb_pcie_tl_vc_scheduler;
  import PCIe_PKG::*;

  localparam int INIT = 16;

  typedef logic [223:0] tlp_t;

  typedef struct {
    bit ne0;
    bit ne1;
    bit rdy;
    bit r0;
    bit r1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  pcie_tl_vc_scheduler_if bus();

  pcie_tl_vc_scheduler #(
    .WEIGHT_VC0    (3),
    .WEIGHT_VC1    (1),
    .INIT_HDR_CRD  (INIT),
    .INIT_DATA_CRD (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  tlp_t q0[$];
  tlp_t q1[$];
  int   wt[2] = '{3, 1};
  int   m_hdr[2];
  int   m_dat[2];
  bit   m_valid;
  tlp_t m_tlp;
  bit   m_vc;
  int   m_turn;
  int   m_run;

  function automatic tlp_t mk(input bit data);
    tlp_t t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    t[223:221] = data ? 3'b010 : 3'b000;
    return t;
  endfunction

  task automatic chk(input string n, input tlp_t act, input tlp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.vc0_empty_i = (q0.size() == 0);
    bus.vc1_empty_i = (q1.size() == 0);
    bus.vc0_rdata_i = (q0.size() != 0) ? q0[0] : '0;
    bus.vc1_rdata_i = (q1.size() != 0) ? q1[0] : '0;
  endtask

  function automatic int sat(input int v);
    return (v > INIT) ? INIT : v;
  endfunction

  task automatic chk_outputs();
    chk("valid", bus.tlp_valid_o, m_valid);
    chk("tlp", bus.tlp_o, m_tlp);
    chk("grant_vc", bus.grant_vc_o, m_vc);
    chk("fc0", bus.vc0_fc_valid_o, m_hdr[0] != 0);
    chk("fc1", bus.vc1_fc_valid_o, m_hdr[1] != 0);
    chk("hdr0", dut.u_crd0.hdr_crd, m_hdr[0]);
    chk("dat0", dut.u_crd0.data_crd, m_dat[0]);
    chk("hdr1", dut.u_crd1.hdr_crd, m_hdr[1]);
    chk("dat1", dut.u_crd1.data_crd, m_dat[1]);
  endtask

  // one clock: predict the grant, check pops, then check the edge result
  task automatic step();
    bit   el[2];
    bit   ne[2];
    tlp_t h[2];
    bit   ld;
    bit   g;
    int   gv;
    int   cur;
    int   v;
    drive();
    #1;
    ne[0] = q0.size() != 0;
    ne[1] = q1.size() != 0;
    h[0]  = ne[0] ? q0[0] : '0;
    h[1]  = ne[1] ? q1[0] : '0;
    for (int i = 0; i < 2; i++)
      el[i] = ne[i] && m_hdr[i] > 0 && (!h[i][222] || m_dat[i] > 0);
    ld  = !m_valid || bus.tlp_ready_i;
    g   = 0;
    gv  = 0;
    cur = m_turn;
    if (ld) begin
      if (el[cur]) begin
        g = 1;
        gv = cur;
        m_run++;
        if (m_run >= wt[cur]) begin
          m_turn = 1 - cur;
          m_run = 0;
        end
      end else if (el[1-cur]) begin
        g = 1;
        gv = 1 - cur;
        m_turn = 1 - cur;
        m_run = 1;
      end
    end
    chk("rden0", bus.vc0_rden_o, g && gv == 0);
    chk("rden1", bus.vc1_rden_o, g && gv == 1);
    @(posedge clk);
    if (ld) begin
      m_valid = g;
      if (g) begin
        m_tlp = h[gv];
        m_vc  = gv[0];
        m_hdr[gv]--;
        if (h[gv][222]) m_dat[gv]--;
        if (gv == 1) void'(q1.pop_front());
        else void'(q0.pop_front());
      end
    end
    if (bus.crd_ret_valid_i) begin
      v = bus.crd_ret_vc_i;
      m_hdr[v] = sat(m_hdr[v] + int'(bus.crd_ret_hdr_i));
      m_dat[v] = sat(m_dat[v] + int'(bus.crd_ret_data_i));
    end
    #1;
    chk_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.crd_ret_valid_i = 1'b0;
    drive();
    #1;
    chk("rst_rden0", bus.vc0_rden_o, 1'b0);
    chk("rst_rden1", bus.vc1_rden_o, 1'b0);
    @(posedge clk);
    m_valid = 0;
    m_tlp   = '0;
    m_vc    = 0;
    m_turn  = 0;
    m_run   = 0;
    for (int i = 0; i < 2; i++) begin
      m_hdr[i] = INIT;
      m_dat[i] = INIT;
    end
    #1;
    chk_outputs();
    chk("rst_state", dut.state, SERVE_VC0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
  endtask

  initial begin
    vec_t tbl[5];
    tlp_t a;
    tlp_t b;
    tlp_t saved;

    bus.tlp_ready_i     = 1'b1;
    bus.crd_ret_valid_i = 1'b0;
    bus.crd_ret_vc_i    = 1'b0;
    bus.crd_ret_hdr_i   = 4'd0;
    bus.crd_ret_data_i  = 4'd0;
    clear_q();
    do_reset();

    // combinational grant choice from an idle output stage
    tbl[0] = '{ne0: 0, ne1: 0, rdy: 1, r0: 0, r1: 0};
    tbl[1] = '{ne0: 1, ne1: 0, rdy: 1, r0: 1, r1: 0};
    tbl[2] = '{ne0: 0, ne1: 1, rdy: 1, r0: 0, r1: 1};
    tbl[3] = '{ne0: 1, ne1: 1, rdy: 1, r0: 1, r1: 0};
    tbl[4] = '{ne0: 1, ne1: 1, rdy: 0, r0: 1, r1: 0};
    for (int i = 0; i < 5; i++) begin
      clear_q();
      if (tbl[i].ne0) q0.push_back(mk(0));
      if (tbl[i].ne1) q1.push_back(mk(1));
      bus.tlp_ready_i = tbl[i].rdy;
      drive();
      #1;
      chk("tbl_rden0", bus.vc0_rden_o, tbl[i].r0);
      chk("tbl_rden1", bus.vc1_rden_o, tbl[i].r1);
    end
    bus.tlp_ready_i = 1'b1;

    // weighted pattern 0,0,0,1
    clear_q();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(0));
      q1.push_back(mk(0));
    end
    for (int k = 0; k < 8; k++) begin
      step();
      chk("wrr_pat", bus.grant_vc_o, (k % 4) == 3);
    end

    // VC1 idle: five VC0 TLPs back to back
    clear_q();
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back(mk(i % 2));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("run_valid", bus.tlp_valid_o, 1'b1);
      chk("run_vc", bus.grant_vc_o, 1'b0);
    end
    step();
    chk("run_end", bus.tlp_valid_o, 1'b0);

    // backpressure holds the output stable
    clear_q();
    do_reset();
    a = mk(0);
    b = mk(1);
    q0.push_back(a);
    q0.push_back(b);
    step();
    saved = bus.tlp_o;
    chk("stall_first", saved, a);
    bus.tlp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_hold", bus.tlp_o, a);
      chk("stall_valid", bus.tlp_valid_o, 1'b1);
    end
    bus.tlp_ready_i = 1'b1;
    step();
    chk("resume", bus.tlp_o, b);

    // drain VC0 header credits, serve VC1, then return credits
    clear_q();
    do_reset();
    for (int i = 0; i < 18; i++) q0.push_back(mk(0));
    for (int k = 0; k < 17; k++) step();
    chk("fc0_drained", bus.vc0_fc_valid_o, 1'b0);
    chk("drained_idle", bus.tlp_valid_o, 1'b0);
    q1.push_back(mk(0));
    q1.push_back(mk(1));
    for (int k = 0; k < 2; k++) begin
      step();
      chk("vc1_only", bus.grant_vc_o, 1'b1);
    end
    bus.crd_ret_valid_i = 1'b1;
    bus.crd_ret_vc_i    = 1'b0;
    bus.crd_ret_hdr_i   = 4'd2;
    bus.crd_ret_data_i  = 4'd0;
    step();
    bus.crd_ret_valid_i = 1'b0;
    step();
    chk("vc0_resume_v", bus.tlp_valid_o, 1'b1);
    chk("vc0_resume_vc", bus.grant_vc_o, 1'b0);

    // return at ceiling with a same-cycle consume
    clear_q();
    do_reset();
    q0.push_back(mk(1));
    bus.crd_ret_valid_i = 1'b1;
    bus.crd_ret_vc_i    = 1'b0;
    bus.crd_ret_hdr_i   = 4'd4;
    bus.crd_ret_data_i  = 4'd4;
    step();
    bus.crd_ret_valid_i = 1'b0;
    chk("sat_hdr", dut.u_crd0.hdr_crd, INIT);
    chk("sat_dat", dut.u_crd0.data_crd, INIT);

    // reset while a TLP is held
    clear_q();
    do_reset();
    q0.push_back(mk(0));
    q0.push_back(mk(0));
    bus.tlp_ready_i = 1'b0;
    step();
    step();
    chk("held_valid", bus.tlp_valid_o, 1'b1);
    do_reset();
    bus.tlp_ready_i = 1'b1;
    step();
    chk("post_rst_vc", bus.grant_vc_o, 1'b0);

    // random traffic
    clear_q();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (q0.size() < 8 && $urandom_range(0, 1) == 0)
        q0.push_back(mk($urandom_range(0, 1) == 1));
      if (q1.size() < 8 && $urandom_range(0, 2) == 0)
        q1.push_back(mk($urandom_range(0, 1) == 1));
      bus.tlp_ready_i     = ($urandom_range(0, 9) < 7);
      bus.crd_ret_valid_i = ($urandom_range(0, 2) == 0);
      bus.crd_ret_vc_i    = $urandom_range(0, 1) == 1;
      bus.crd_ret_hdr_i   = 4'($urandom_range(0, 4));
      bus.crd_ret_data_i  = 4'($urandom_range(0, 4));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcie_tl_vc_scheduler.md
PCIE_TL_VC_SCHEDULER -- requirements
Module: pcie_tl_vc_scheduler

Interface
REQ-001 SHALL have parameter WEIGHT_VC0, default 3, max consecutive VC0 grants per turn (1..15).
REQ-002 SHALL have parameter WEIGHT_VC1, default 1, max consecutive VC1 grants per turn (1..15).
REQ-003 SHALL have parameter INIT_HDR_CRD, default 16, per-VC header credit at reset and ceiling.
REQ-004 SHALL have parameter INIT_DATA_CRD, default 16, per-VC data credit at reset and ceiling.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have ports vc0_empty_i/vc1_empty_i  input  1 each  VC FIFO empty; FIFOs are first-word-fall-through.
REQ-008 SHALL have ports vc0_rdata_i/vc1_rdata_i  input  PCIe_TL_TLP_PACKET_SIZE (224) each  FIFO head TLP; header in [223:128], fmt in [223:221].
REQ-009 SHALL have ports vc0_rden_o/vc1_rden_o  output  1 each  pop the FIFO head.
REQ-010 SHALL have port tlp_valid_o  output  1  TLP valid towards data link layer.
REQ-011 SHALL have port tlp_o  output  224  TLP towards data link layer.
REQ-012 SHALL have port tlp_ready_i  input  1  data link layer accepts.
REQ-013 SHALL have port crd_ret_valid_i  input  1  credit return strobe.
REQ-014 SHALL have port crd_ret_vc_i  input  1  VC of returned credits.
REQ-015 SHALL have ports crd_ret_hdr_i/crd_ret_data_i  input  4 each  header/data credits returned.
REQ-016 SHALL have ports vc0_fc_valid_o/vc1_fc_valid_o  output  1 each  VC has >=1 header credit; drives upstream fc_valid.
REQ-017 SHALL have port grant_vc_o  output  1  VC of TLP currently in tlp_o.

Function
REQ-018 Eligibility: VCn eligible when !vcn_empty_i, hdr_crd[n]>=1, and (fmt[1]==0 or data_crd[n]>=1).
REQ-019 Load condition: output stage may load when !tlp_valid_o or tlp_ready_i.
REQ-020 On load with a granted VC: tlp_o<=head, grant_vc_o<=VC, tlp_valid_o<=1, and that VC's rden_o asserted the same cycle (combinational); at most one rden_o high per cycle.
REQ-021 tlp_valid_o/tlp_o SHALL hold stable while tlp_valid_o && !tlp_ready_i; no pop occurs then.
REQ-022 If load condition true and no VC eligible, tlp_valid_o<=0 next edge.
REQ-023 Latency: eligible head with idle output -> tlp_valid_o high next cycle; back-to-back TLPs at one per cycle when tlp_ready_i held high.
REQ-024 FSM states SERVE_VC0, SERVE_VC1, with 4-bit grant counter cnt.
REQ-025 In SERVE_VCn: grant VCn if eligible, cnt++; when cnt reaches WEIGHT_VCn, go to other state, cnt<=0.
REQ-026 In SERVE_VCn, VCn ineligible and other VC eligible: grant the other VC this cycle, switch state, cnt<=1.
REQ-027 Neither eligible, or load condition false: state and cnt unchanged.
REQ-028 Credit consumption on grant: hdr_crd[n]-=1; data_crd[n]-=1 if fmt[1]==1.
REQ-029 Credit return: hdr/data credits of crd_ret_vc_i += returned amounts, saturating at INIT_HDR_CRD/INIT_DATA_CRD.
REQ-030 Simultaneous consume and return on same VC: new = min(cur - consume + return, INIT); never underflows (consume only when eligible).
REQ-031 vcn_fc_valid_o = (hdr_crd[n]!=0), combinational from registered credit.

Reset
REQ-032 On rst: tlp_valid_o=0, tlp_o=0, grant_vc_o=0, state=SERVE_VC0, cnt=0, hdr_crd=INIT_HDR_CRD, data_crd=INIT_DATA_CRD, rden_o=0.
REQ-033 Reset mid-transfer discards the held TLP; the FIFOs are not reset by this block.

Structure
REQ-034 PCIe_PKG SHALL hold PCIe_TL_TLP_PACKET_SIZE, the FSM state enum, credit width constant (8), and a function tlp_has_data(fmt).
REQ-035 One sub-module pcie_tl_vc_credit_cnt (one instance per VC) SHALL hold the hdr/data counters and saturation logic.

Verification
REQ-036 Both FIFOs always non-empty, ready=1, ample credits -> grant pattern 0,0,0,1 repeating.
REQ-037 VC1 empty, VC0 has 5 TLPs -> 5 VC0 TLPs on consecutive cycles, state never stalls.
REQ-038 ready=0 for 3 cycles while valid -> tlp_o stable, no rden_o pulse, resumes on ready=1.
REQ-039 VC0 hdr credits drained to 0 -> vc0_fc_valid_o=0, only VC1 served; return 2 hdr credits -> VC0 resumes.
REQ-040 Return 4 credits at INIT and consume same cycle -> counter = INIT, no wrap.
REQ-041 rst asserted while tlp_valid_o=1 -> next cycle tlp_valid_o=0, credits=INIT, state SERVE_VC0.
